// File: rtl/load_unit_mc.sv
// load_unit_mc: multi-cycle RV32I load execution unit.
// Forms the effective address, runs a valid/ready word read on the data-memory port,
// then aligns and extends the loaded value and offers it on a write-back handshake.
// Optional build macro LOAD_MISALIGN_SPLIT_EN: misaligned halfword/word loads are served
// with two word reads (extra states REQ2/WAIT2) instead of a misaligned fault.
module load_unit_mc #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [11:0]       imm,
    input  logic [4:0]        rd,
    input  logic [2:0]        load_control,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic [1:0]        wb_fault
);

    // Load codes follow the RV32I funct3 encoding; LD_NOP marks "no load".
    localparam logic [2:0] LC_LB     = 3'b000;
    localparam logic [2:0] LC_LH     = 3'b001;
    localparam logic [2:0] LC_LW     = 3'b010;
    localparam logic [2:0] LC_LBU    = 3'b100;
    localparam logic [2:0] LC_LHU    = 3'b101;
    localparam logic [2:0] LC_LD_NOP = 3'b111;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b10;

    // Counter only has to reach TIMEOUT_CYC-1 (the last WAIT cycle).
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    if (XLEN != 32) begin : g_xlen_check
        $error("load_unit_mc supports XLEN = 32 only");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
`ifdef LOAD_MISALIGN_SPLIT_EN
        ,
        S_REQ2,
        S_WAIT2
`endif
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        off_q, off_d;
    logic [2:0]        ctl_q, ctl_d;
    logic [4:0]        rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [1:0]        wb_fault_q, wb_fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef LOAD_MISALIGN_SPLIT_EN
    logic [XLEN-1:0]   lo_q, lo_d;
`else
    logic              mis_in;
`endif

    logic [ADDR_W-1:0] ea_in;
    logic              accept;
    logic              in_wait;
    logic              timeout_hit;
    logic [2*XLEN-1:0] pair;
    logic [XLEN-1:0]   aligned;
    logic [XLEN-1:0]   fin_data;
    logic [1:0]        fin_fault;
    logic [4:0]        fin_rd;

    function automatic logic ctl_ok(input logic [2:0] c);
        case (c)
            LC_LB, LC_LH, LC_LW, LC_LBU, LC_LHU: ctl_ok = 1'b1;
            LC_LD_NOP:                          ctl_ok = 1'b0;
            default:                            ctl_ok = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] c, input logic [1:0] off);
        case (c)
            LC_LH, LC_LHU: misaligned = off[0];
            LC_LW:         misaligned = (off != 2'b00);
            default:       misaligned = 1'b0;
        endcase
    endfunction

    // w is already shifted so the addressed byte sits in bits [7:0].
    function automatic logic [XLEN-1:0] extend(input logic [2:0] c, input logic [XLEN-1:0] w);
        case (c)
            LC_LB:   extend = {{(XLEN-8){w[7]}}, w[7:0]};
            LC_LBU:  extend = {{(XLEN-8){1'b0}}, w[7:0]};
            LC_LH:   extend = {{(XLEN-16){w[15]}}, w[15:0]};
            LC_LHU:  extend = {{(XLEN-16){1'b0}}, w[15:0]};
            LC_LW:   extend = w;
            default: extend = '0;
        endcase
    endfunction

    assign ea_in       = ADDR_W'(rs1_val) + {{(ADDR_W-12){imm[11]}}, imm};
    assign accept      = in_valid && in_ready;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);
`ifdef LOAD_MISALIGN_SPLIT_EN
    assign in_wait = (state_q == S_WAIT) || (state_q == S_WAIT2);
    // Second word of a split access supplies the upper half of the little-endian pair.
    assign pair    = (state_q == S_WAIT2) ? {mem_rdata, lo_q} : {{XLEN{1'b0}}, mem_rdata};
`else
    assign in_wait = (state_q == S_WAIT);
    assign mis_in  = misaligned(load_control, ea_in[1:0]);
    assign pair    = {{XLEN{1'b0}}, mem_rdata};
`endif
    assign aligned = pair[{off_q, 3'b000} +: XLEN];

    assign mem_addr = addr_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_fault = wb_fault_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && ctl_ok(load_control)) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
                    state_d = S_REQ;
`else
                    state_d = mis_in ? S_DONE : S_REQ;
`endif
                end
            end
            S_REQ:  if (mem_req_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (mem_rsp_valid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
                    state_d = misaligned(ctl_q, off_q) ? S_REQ2 : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
`ifdef LOAD_MISALIGN_SPLIT_EN
            S_REQ2:  if (mem_req_ready) state_d = S_WAIT2;
            S_WAIT2: if (mem_rsp_valid || timeout_hit) state_d = S_DONE;
`endif
            S_DONE:  if (wb_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        wb_valid      = 1'b0;
        case (state_q)
            S_IDLE:  in_ready      = 1'b1;
            S_REQ:   mem_req_valid = 1'b1;
`ifdef LOAD_MISALIGN_SPLIT_EN
            S_REQ2:  mem_req_valid = 1'b1;
`endif
            S_DONE:  wb_valid      = 1'b1;
            default: ;
        endcase
    end

    // Write-back values for whichever transition enters DONE this cycle
    always_comb begin
        fin_rd    = (state_q == S_IDLE) ? rd : rd_q;
        fin_data  = '0;
        fin_fault = FLT_TIMEOUT;
        if (state_q == S_IDLE) begin
            fin_fault = FLT_MISALIGN;
        end else if (mem_rsp_valid) begin
            fin_data  = extend(ctl_q, aligned);
            fin_fault = FLT_NONE;
        end
    end

    // Datapath next-state: request capture, address stepping, result latch
    always_comb begin
        off_d      = off_q;
        ctl_d      = ctl_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_fault_d = wb_fault_q;
`ifdef LOAD_MISALIGN_SPLIT_EN
        lo_d       = lo_q;
`endif
        // Count WAIT cycles; any non-WAIT cycle (and every state change) clears it.
        cnt_d      = '0;
        if ((TIMEOUT_CYC != 0) && in_wait && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);

        if (accept) begin
            off_d  = ea_in[1:0];
            ctl_d  = load_control;
            rd_d   = rd;
            addr_d = {ea_in[ADDR_W-1:2], 2'b00};
        end
`ifdef LOAD_MISALIGN_SPLIT_EN
        if ((state_q == S_WAIT) && (state_d == S_REQ2)) begin
            lo_d   = mem_rdata;
            addr_d = {addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
        end
`endif
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            wb_rd_d    = fin_rd;
            wb_data_d  = fin_data;
            wb_fault_d = fin_fault;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q      <= '0;
            ctl_q      <= LC_LD_NOP;
            rd_q       <= '0;
            addr_q     <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_fault_q <= FLT_NONE;
            cnt_q      <= '0;
`ifdef LOAD_MISALIGN_SPLIT_EN
            lo_q       <= '0;
`endif
        end else begin
            off_q      <= off_d;
            ctl_q      <= ctl_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_fault_q <= wb_fault_d;
            cnt_q      <= cnt_d;
`ifdef LOAD_MISALIGN_SPLIT_EN
            lo_q       <= lo_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_unit_mc.sv
// Directed testbench for load_unit_mc (TIMEOUT_CYC = 8).
module tb_load_unit_mc;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
    localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, LD_NOP = 3'b111;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] rs1_val;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [2:0]  load_control;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_fault;

    int n_assert = 0;
    int n_fail   = 0;

    load_unit_mc #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_val(rs1_val), .imm(imm), .rd(rd), .load_control(load_control),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_fault(wb_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] r, input logic [11:0] i, input logic [2:0] c,
                         input logic [4:0] d);
        in_valid     = 1'b1;
        rs1_val      = r;
        imm          = i;
        load_control = c;
        rd           = d;
        tick();
        in_valid     = 1'b0;
    endtask

    task automatic serve_req(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
        int n;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_req_seen"}, 32'(mem_req_valid), 32'd1);
        check_eq({tag, "_addr"}, mem_addr, exp_addr);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = word;
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic take_wb(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_fault,
                           input logic [4:0] exp_rd);
        int n;
        n = 0;
        while (!wb_valid && n < 30) begin
            tick();
            n++;
        end
        check_eq({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check_eq({tag, "_wb_data"}, wb_data, exp_data);
        check_eq({tag, "_wb_fault"}, 32'(wb_fault), 32'(exp_fault));
        check_eq({tag, "_wb_rd"}, 32'(wb_rd), 32'(exp_rd));
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check_eq({tag, "_wb_drop"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        int  n;
        logic busy;
        rst_n = 1'b0; in_valid = 1'b0; rs1_val = '0; imm = '0; rd = '0; load_control = LD_NOP;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; wb_ready = 1'b0;

        // Reset values
        tick(); tick();
        check_eq("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_wb_fault", 32'(wb_fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: LW, zero-wait, exact cycle timing
        issue(32'h1000, 12'h004, LW, 5'd5);
        check_eq("t1_c1_req_valid", 32'(mem_req_valid), 32'd1);
        check_eq("t1_c1_addr", mem_addr, 32'h1004);
        check_eq("t1_c1_in_ready", 32'(in_ready), 32'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check_eq("t1_c2_req_valid", 32'(mem_req_valid), 32'd0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rsp_valid = 1'b0;
        check_eq("t1_c3_wb_valid", 32'(wb_valid), 32'd1);
        take_wb("t1", 32'hDEADBEEF, 2'b00, 5'd5);
        check_eq("t1_in_ready_back", 32'(in_ready), 32'd1);

        // 2: byte loads at EA 0x2003
        issue(32'h2000, 12'h003, LB, 5'd7);
        serve_req("t2_lb", 32'h2000, 32'h80123456);
        take_wb("t2_lb", 32'hFFFFFF80, 2'b00, 5'd7);
        issue(32'h2000, 12'h003, LBU, 5'd7);
        serve_req("t2_lbu", 32'h2000, 32'h80123456);
        take_wb("t2_lbu", 32'h00000080, 2'b00, 5'd7);

        // Further extract/extend patterns, negative offset, address wrap, rd=0
        issue(32'h2000, 12'h000, LH, 5'd1);
        serve_req("x_lh0", 32'h2000, 32'h12348765);
        take_wb("x_lh0", 32'hFFFF8765, 2'b00, 5'd1);
        issue(32'h2000, 12'h000, LHU, 5'd2);
        serve_req("x_lhu0", 32'h2000, 32'h12348765);
        take_wb("x_lhu0", 32'h00008765, 2'b00, 5'd2);
        issue(32'h2000, 12'h001, LB, 5'd0);
        serve_req("x_lb1", 32'h2000, 32'h00007F00);
        take_wb("x_lb1", 32'h0000007F, 2'b00, 5'd0);
        issue(32'h2010, 12'hFFC, LW, 5'd31);
        serve_req("x_negimm", 32'h200C, 32'hCAFEF00D);
        take_wb("x_negimm", 32'hCAFEF00D, 2'b00, 5'd31);
        issue(32'hFFFFFFFC, 12'h008, LBU, 5'd6);
        serve_req("x_wrap", 32'h00000004, 32'h000000A5);
        take_wb("x_wrap", 32'h000000A5, 2'b00, 5'd6);

        // 3: LH at EA 0x2002 with request and write-back backpressure
        issue(32'h2000, 12'h002, LH, 5'd9);
        busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!mem_req_valid || mem_addr != 32'h2000) busy = 1'b1;
            tick();
        end
        check_eq("t3_req_stable", 32'(busy), 32'd0);
        serve_req("t3", 32'h2000, 32'h80015555);
        busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!wb_valid || wb_data != 32'hFFFF8001 || wb_rd != 5'd9 || wb_fault != 2'b00) busy = 1'b1;
            tick();
        end
        check_eq("t3_wb_stable", 32'(busy), 32'd0);
        take_wb("t3", 32'hFFFF8001, 2'b00, 5'd9);

        // 4: misaligned LW at EA 0x3001
        issue(32'h3000, 12'h001, LW, 5'd3);
`ifdef LOAD_MISALIGN_SPLIT_EN
        serve_req("t4_lo", 32'h3000, 32'h44332211);
        serve_req("t4_hi", 32'h3004, 32'h88776655);
        take_wb("t4", 32'h55443322, 2'b00, 5'd3);
`else
        check_eq("t4_no_req", 32'(mem_req_valid), 32'd0);
        check_eq("t4_direct_done", 32'(wb_valid), 32'd1);
        take_wb("t4", 32'h00000000, 2'b01, 5'd3);
`endif

        // 5: bus timeout after 8 WAIT cycles; late response ignored
        issue(32'h5000, 12'h000, LW, 5'd4);
        check_eq("t5_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        n = 0;
        while (!wb_valid && n < 50) begin
            tick();
            n++;
        end
        check_eq("t5_wait_cycles", 32'(n), 32'd8);
        check_eq("t5_fault", 32'(wb_fault), 32'd2);
        check_eq("t5_data", wb_data, 32'd0);
        tick(); tick();
        mem_rsp_valid = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_rsp_valid = 1'b0;
        check_eq("t5_late_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("t5_late_data", wb_data, 32'd0);
        check_eq("t5_late_fault", 32'(wb_fault), 32'd2);
        take_wb("t5", 32'h00000000, 2'b10, 5'd4);
        check_eq("t5_no_req_after", 32'(mem_req_valid), 32'd0);

        // 6: asynchronous reset while in WAIT
        issue(32'h6000, 12'h000, LW, 5'd12);
        serve_req("t6_pre", 32'h6000, 32'h11111111);
        take_wb("t6_pre", 32'h11111111, 2'b00, 5'd12);
        issue(32'h6000, 12'h008, LW, 5'd11);
        check_eq("t6_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_req_valid", 32'(mem_req_valid), 32'd0);
        check_eq("t6_rst_addr", mem_addr, 32'd0);
        check_eq("t6_rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("t6_rst_wb_rd", 32'(wb_rd), 32'd0);
        check_eq("t6_rst_wb_data", wb_data, 32'd0);
        check_eq("t6_rst_wb_fault", 32'(wb_fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("t6_in_ready", 32'(in_ready), 32'd1);

        // LD_NOP and an undefined code are accepted and dropped
        issue(32'h7000, 12'h000, LD_NOP, 5'd13);
        busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (mem_req_valid || wb_valid || !in_ready) busy = 1'b1;
            tick();
        end
        check_eq("nop_quiet", 32'(busy), 32'd0);
        issue(32'h7000, 12'h000, 3'b011, 5'd14);
        busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (mem_req_valid || wb_valid || !in_ready) busy = 1'b1;
            tick();
        end
        check_eq("undef_quiet", 32'(busy), 32'd0);
        issue(32'h7000, 12'h004, LHU, 5'd15);
        serve_req("post_nop", 32'h7004, 32'hBEEF0123);
        take_wb("post_nop", 32'h00000123, 2'b00, 5'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
